// File: rtl/fp_norm_iter.sv
// Iterative floating-point normaliser: shifts the mantissa left by up to STEP bits
// per cycle (or right once on carry-out) and flags zero, underflow and overflow.
module fp_norm_iter #(
  parameter int MANTISSA = 11,
  parameter int EXPONENT = 5,
  parameter int STEP     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXPONENT-1:0]   in_exponent,
  input  logic [MANTISSA:0]     in_mantissa,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXPONENT-1:0]   out_exponent,
  output logic [MANTISSA-1:0]   out_mantissa,
  output logic [EXPONENT-1:0]   out_shift,
  output logic                  out_zero,
  output logic                  out_underflow,
  output logic                  out_overflow
);

  localparam int CW = EXPONENT + 1;
  localparam logic [EXPONENT-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_next;
  logic                sign_q, sign_d;
  logic [EXPONENT-1:0] exp_q, exp_d, exp_inc;
  logic [MANTISSA:0]   mant_q, mant_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                zero_q, zero_d, unf_q, unf_d, ovf_q, ovf_d;
  logic                found;
  int                  lz, s;

  // Leading zeros below the hidden-bit position, clamped to the per-cycle step
  // and to the exponent so a denormal never goes below exponent zero.
  always_comb begin
    lz    = 0;
    found = 1'b0;
    for (int i = MANTISSA - 1; i >= 0; i--) begin
      if (!found) begin
        if (mant_q[i]) found = 1'b1;
        else           lz++;
      end
    end
    s = lz;
    if (s > STEP)         s = STEP;
    if (s > int'(exp_q))  s = int'(exp_q);
  end

  assign exp_inc = exp_q + EXPONENT'(1);

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    cnt_d      = cnt_q;
    zero_d     = zero_q;
    unf_d      = unf_q;
    ovf_d      = ovf_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sign_d     = in_sign;
          exp_d      = in_exponent;
          mant_d     = in_mantissa;
          cnt_d      = '0;
          zero_d     = 1'b0;
          unf_d      = 1'b0;
          ovf_d      = 1'b0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (exp_q == EXP_MAX) begin
          state_next = DONE;
        end else if (mant_q[MANTISSA]) begin
          mant_d     = {1'b0, mant_q[MANTISSA:1]};
          exp_d      = exp_inc;
          if (exp_inc == EXP_MAX) begin
            mant_d = '0;
            ovf_d  = 1'b1;
          end
          state_next = DONE;
        end else if (mant_q == '0) begin
          exp_d      = '0;
          zero_d     = 1'b1;
          state_next = DONE;
        end else if (mant_q[MANTISSA-1]) begin
          state_next = DONE;
        end else if (exp_q == '0) begin
          unf_d      = 1'b1;
          state_next = DONE;
        end else begin
          mant_d = mant_q << s;
          exp_d  = exp_q - EXPONENT'(s);
          cnt_d  = cnt_q + CW'(s);
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
      unf_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_next;
      sign_q <= sign_d;
      exp_q  <= exp_d;
      mant_q <= mant_d;
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
      unf_q  <= unf_d;
      ovf_q  <= ovf_d;
    end
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign out_sign      = sign_q;
  assign out_exponent  = exp_q;
  assign out_mantissa  = mant_q[MANTISSA-1:0];
  assign out_shift     = cnt_q[EXPONENT] ? EXP_MAX : cnt_q[EXPONENT-1:0];
  assign out_zero      = zero_q;
  assign out_underflow = unf_q;
  assign out_overflow  = ovf_q;

endmodule

// File: tb/tb_fp_norm_iter.sv
// Self-checking bench for fp_norm_iter: directed vectors, hold/reset sequences and
// random operands checked against a whole-result reference model.
module tb_fp_norm_iter;

  localparam int M = 11;
  localparam int E = 5;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [E-1:0]  in_exponent = '0;
  logic [M:0]    in_mantissa = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sign;
  logic [E-1:0]  out_exponent;
  logic [M-1:0]  out_mantissa;
  logic [E-1:0]  out_shift;
  logic          out_zero, out_underflow, out_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_norm_iter #(.MANTISSA(M), .EXPONENT(E), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exponent(out_exponent), .out_mantissa(out_mantissa),
    .out_shift(out_shift), .out_zero(out_zero),
    .out_underflow(out_underflow), .out_overflow(out_overflow)
  );

  typedef struct {
    logic         sign;
    logic [E-1:0] exp_in;
    logic [M:0]   mant_in;
    logic [E-1:0] e_exp;
    logic [M-1:0] e_mant;
    logic [E-1:0] e_shift;
    logic         e_zero;
    logic         e_unf;
    logic         e_ovf;
    int           lat;   // 0 = latency not checked
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [E-1:0] e, input logic [M:0] m,
                              input logic [E-1:0] xe, input logic [M-1:0] xm,
                              input logic [E-1:0] xs, input logic z, input logic u,
                              input logic o, input int lat);
    vec_t v;
    v.sign = s; v.exp_in = e; v.mant_in = m;
    v.e_exp = xe; v.e_mant = xm; v.e_shift = xs;
    v.e_zero = z; v.e_unf = u; v.e_ovf = o; v.lat = lat;
    return v;
  endfunction

  // Whole-result model: find the leading one, shift by the full distance at once
  // (limited by the exponent), and derive flags from the outcome.
  function automatic vec_t model(input logic s, input logic [E-1:0] e, input logic [M:0] m);
    vec_t r;
    int p, need, tot;
    r = mk(s, e, m, e, m[M-1:0], '0, 1'b0, 1'b0, 1'b0, 1);
    if (e == '1) begin
      // pass-through
    end else if (m[M]) begin
      r.e_exp  = e + 5'd1;
      r.e_mant = m[M:1];
      if (r.e_exp == '1) begin
        r.e_mant = '0;
        r.e_ovf  = 1'b1;
      end
    end else if (m == '0) begin
      r.e_exp  = '0;
      r.e_zero = 1'b1;
    end else begin
      p = 0;
      for (int i = 0; i < M; i++) if (m[i]) p = i;
      need = (M - 1) - p;
      tot  = (need < int'(e)) ? need : int'(e);
      r.e_mant  = M'(m << tot);
      r.e_exp   = e - E'(tot);
      r.e_shift = E'(tot);
      if (tot < need) begin
        r.e_unf = 1'b1;
        r.lat   = 0;
      end else begin
        r.lat = 1 + (need + STEP - 1) / STEP;
      end
    end
    return r;
  endfunction

  task automatic drive(input vec_t v);
    in_sign     = v.sign;
    in_exponent = v.exp_in;
    in_mantissa = v.mant_in;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns the edge count after capture at which out_valid was seen, or -1.
  task automatic wait_done(input string tag, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check({tag, ".timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".sign"},  32'(out_sign),      32'(v.sign));
    check({tag, ".exp"},   32'(out_exponent),  32'(v.e_exp));
    check({tag, ".mant"},  32'(out_mantissa),  32'(v.e_mant));
    check({tag, ".shift"}, 32'(out_shift),     32'(v.e_shift));
    check({tag, ".flags"}, {29'd0, out_zero, out_underflow, out_overflow},
                           {29'd0, v.e_zero, v.e_unf, v.e_ovf});
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int lat;
    drive(v);
    wait_done(tag, lat);
    if (lat < 0) return;
    if (v.lat != 0) check({tag, ".lat"}, 32'(lat), 32'(v.lat));
    check_outputs(tag, v);
    @(posedge clk);
    #1 check({tag, ".back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  vec_t tbl[8];
  vec_t deep;
  vec_t rv;
  int   lat;

  initial begin
    tbl[0] = mk(1'b0, 5'd15, 12'h400, 5'd15, 11'h400, 5'd0,  1'b0, 1'b0, 1'b0, 1);
    tbl[1] = mk(1'b1, 5'd20, 12'h001, 5'd10, 11'h400, 5'd10, 1'b0, 1'b0, 1'b0, 4);
    tbl[2] = mk(1'b0, 5'd15, 12'hC01, 5'd16, 11'h600, 5'd0,  1'b0, 1'b0, 1'b0, 1);
    tbl[3] = mk(1'b0, 5'd30, 12'h800, 5'd31, 11'h000, 5'd0,  1'b0, 1'b0, 1'b1, 1);
    tbl[4] = mk(1'b0, 5'd3,  12'h010, 5'd0,  11'h080, 5'd3,  1'b0, 1'b1, 1'b0, 0);
    tbl[5] = mk(1'b0, 5'd12, 12'h000, 5'd0,  11'h000, 5'd0,  1'b1, 1'b0, 1'b0, 1);
    tbl[6] = mk(1'b1, 5'd31, 12'h123, 5'd31, 11'h123, 5'd0,  1'b0, 1'b0, 1'b0, 1);
    tbl[7] = mk(1'b0, 5'd0,  12'h100, 5'd0,  11'h100, 5'd0,  1'b0, 1'b1, 1'b0, 1);

    #12;
    check("reset.ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("reset.outputs", {out_exponent, out_mantissa, out_shift, out_sign,
                            out_zero, out_underflow, out_overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), tbl[i]);

    // Downstream stall: result must hold while out_ready is low.
    deep = tbl[1];
    out_ready = 1'b0;
    drive(deep);
    wait_done("hold", lat);
    if (lat > 0) begin
      repeat (5) @(posedge clk);
      #1;
      check("hold.valid_ready", {30'd0, in_ready, out_valid}, 32'd1);
      check_outputs("hold", deep);
      out_ready = 1'b1;
      @(posedge clk);
      #1 check("hold.release", {30'd0, in_ready, out_valid}, 32'd2);
    end
    out_ready = 1'b1;

    // Asynchronous reset during the second SHIFT cycle.
    drive(deep);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst.ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("rst.outputs", {out_exponent, out_mantissa, out_shift, out_sign,
                          out_zero, out_underflow, out_overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("after_rst", tbl[2]);

    // Random operands against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic          s;
      logic [E-1:0]  e;
      logic [M:0]    m;
      s = 1'($urandom);
      e = E'($urandom_range(0, 31));
      m = (M + 1)'($urandom_range(0, 4095) >> $urandom_range(0, 12));
      rv = model(s, e, m);
      run_op($sformatf("rnd%0d", i), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
